// File: rtl/systolic_result_drain_pkg.sv
// Shared types and constants for the 3x3 systolic-array result drain.
package systolic_result_drain_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam int NUM_ELEMS = 9;
    localparam int IDX_WIDTH = 4;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_ELEMS - 1);

endpackage

// File: rtl/systolic_result_drain_requant_sat.sv
// Combinational requantizer: arithmetic right shift, optional ReLU,
// signed saturation from RESULT_WIDTH down to OUT_WIDTH.
module requant_sat #(
    parameter int RESULT_WIDTH = 16,
    parameter int OUT_WIDTH    = 8,
    parameter int SHIFT_WIDTH  = 4
) (
    input  logic signed [RESULT_WIDTH-1:0] value_in,
    input  logic [SHIFT_WIDTH-1:0]         shift_amt,
    input  logic                           relu_en,
    output logic [OUT_WIDTH-1:0]           value_out,
    output logic                           sat
);

    localparam logic signed [RESULT_WIDTH-1:0] MAX_V =
        {{(RESULT_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RESULT_WIDTH-1:0] MIN_V =
        {{(RESULT_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic                           shift_ovf;
    logic signed [RESULT_WIDTH-1:0] shifted;

    // Only build the oversized-shift check when the shift field can reach it.
    if ((2 ** SHIFT_WIDTH) > RESULT_WIDTH) begin : g_ovf
        assign shift_ovf = (32'(shift_amt) >= 32'(RESULT_WIDTH));
    end else begin : g_no_ovf
        assign shift_ovf = 1'b0;
    end

    always_comb begin
        shifted   = '0;
        value_out = '0;
        sat       = 1'b0;
        if (shift_ovf) begin
            shifted = {RESULT_WIDTH{value_in[RESULT_WIDTH-1]}};
        end else begin
            shifted = value_in >>> shift_amt;
        end
        if (relu_en && shifted[RESULT_WIDTH-1]) begin
            shifted = '0;
        end
        if (shifted > MAX_V) begin
            value_out = MAX_V[OUT_WIDTH-1:0];
            sat       = 1'b1;
        end else if (shifted < MIN_V) begin
            value_out = MIN_V[OUT_WIDTH-1:0];
            sat       = 1'b1;
        end else begin
            value_out = shifted[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/systolic_result_drain.sv
// Captures a 3x3 result frame on valid_in and streams the nine requantized
// elements row-major over valid/ready, allowing back-to-back frames.
module systolic_result_drain
    import systolic_result_drain_pkg::*;
#(
    parameter int RESULT_WIDTH = 16,
    parameter int OUT_WIDTH    = 8,
    parameter int SHIFT_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [RESULT_WIDTH-1:0] c00_in,
    input  logic [RESULT_WIDTH-1:0] c01_in,
    input  logic [RESULT_WIDTH-1:0] c02_in,
    input  logic [RESULT_WIDTH-1:0] c10_in,
    input  logic [RESULT_WIDTH-1:0] c11_in,
    input  logic [RESULT_WIDTH-1:0] c12_in,
    input  logic [RESULT_WIDTH-1:0] c20_in,
    input  logic [RESULT_WIDTH-1:0] c21_in,
    input  logic [RESULT_WIDTH-1:0] c22_in,
    input  logic                    valid_in,
    input  logic [SHIFT_WIDTH-1:0]  shift_amt,
    input  logic                    relu_en,
    output logic [OUT_WIDTH-1:0]    m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic [IDX_WIDTH-1:0]    m_index,
    output logic                    m_sat,
    output logic                    busy,
    output logic                    drop_err
);

    logic [RESULT_WIDTH-1:0] c_in    [NUM_ELEMS];
    logic [RESULT_WIDTH-1:0] frame_q [NUM_ELEMS];

    state_t                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
    logic                   relu_q, relu_d;
    logic                   drop_err_q, drop_err_d;
    logic                   capture;
    logic                   xfer;
    logic                   streaming;
    logic [OUT_WIDTH-1:0]   rq_data;
    logic                   rq_sat;

    assign c_in[0] = c00_in;
    assign c_in[1] = c01_in;
    assign c_in[2] = c02_in;
    assign c_in[3] = c10_in;
    assign c_in[4] = c11_in;
    assign c_in[5] = c12_in;
    assign c_in[6] = c20_in;
    assign c_in[7] = c21_in;
    assign c_in[8] = c22_in;

    assign streaming = (state_q == STREAM);
    assign xfer      = streaming && m_ready;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        relu_d     = relu_q;
        drop_err_d = drop_err_q;
        capture    = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    capture = 1'b1;
                end
            end
            STREAM: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        // A new frame landing on the final transfer reuses the slot with no bubble.
                        if (valid_in) begin
                            capture = 1'b1;
                        end else begin
                            state_d = IDLE;
                            idx_d   = '0;
                        end
                    end else begin
                        idx_d = idx_q + IDX_WIDTH'(1);
                    end
                end
                if (valid_in && !capture) begin
                    drop_err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
        if (capture) begin
            state_d = STREAM;
            idx_d   = '0;
            shift_d = shift_amt;
            relu_d  = relu_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            relu_q     <= relu_d;
            drop_err_q <= drop_err_d;
        end
    end

    // Frame storage carries no reset; its contents only matter while streaming.
    for (genvar gi = 0; gi < NUM_ELEMS; gi++) begin : g_frame
        always_ff @(posedge clk) begin
            if (capture) begin
                frame_q[gi] <= c_in[gi];
            end
        end
    end

    requant_sat #(
        .RESULT_WIDTH (RESULT_WIDTH),
        .OUT_WIDTH    (OUT_WIDTH),
        .SHIFT_WIDTH  (SHIFT_WIDTH)
    ) u_requant (
        .value_in  (frame_q[idx_q]),
        .shift_amt (shift_q),
        .relu_en   (relu_q),
        .value_out (rq_data),
        .sat       (rq_sat)
    );

    assign m_valid  = streaming;
    assign m_data   = streaming ? rq_data : '0;
    assign m_sat    = streaming && rq_sat;
    assign m_index  = streaming ? idx_q : '0;
    assign m_last   = streaming && (idx_q == LAST_IDX);
    assign busy     = streaming;
    assign drop_err = drop_err_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Randomized scoreboard bench for systolic_result_drain with a frame-level reference model.
module tb_systolic_result_drain;

    localparam int RW = 16;
    localparam int OW = 8;
    localparam int SW = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [RW-1:0] c [9];
    logic                 valid_in = 1'b0;
    logic [SW-1:0]        shift_amt = '0;
    logic                 relu_en = 1'b0;
    logic [OW-1:0]        m_data;
    logic                 m_valid;
    logic                 m_ready = 1'b0;
    logic                 m_last;
    logic [3:0]           m_index;
    logic                 m_sat;
    logic                 busy;
    logic                 drop_err;

    typedef struct {
        int data;
        bit sat;
        int index;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   pending  = 0;
    bit   exp_drop = 1'b0;
    bit   started  = 1'b0;
    bit   xfer_m;
    bit   accept_m;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    systolic_result_drain #(
        .RESULT_WIDTH (RW),
        .OUT_WIDTH    (OW),
        .SHIFT_WIDTH  (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .c00_in    (c[0]),
        .c01_in    (c[1]),
        .c02_in    (c[2]),
        .c10_in    (c[3]),
        .c11_in    (c[4]),
        .c12_in    (c[5]),
        .c20_in    (c[6]),
        .c21_in    (c[7]),
        .c22_in    (c[8]),
        .valid_in  (valid_in),
        .shift_amt (shift_amt),
        .relu_en   (relu_en),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .m_index   (m_index),
        .m_sat     (m_sat),
        .busy      (busy),
        .drop_err  (drop_err)
    );

    task automatic chk(input string nm, input logic signed [31:0] act, input int exp);
        total++;
        if (act !== 32'(exp)) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Floor division by 2^s, then ReLU, then clamp to the signed output range.
    function automatic void ref_elem(input int v, input int s, input bit r,
                                     output int q, output bit st);
        int t;
        int d;
        if (s >= RW) begin
            t = (v < 0) ? -1 : 0;
        end else begin
            d = 1 << s;
            if (v >= 0) t = v / d;
            else        t = -((-v + d - 1) / d);
        end
        if (r && t < 0) t = 0;
        st = 1'b0;
        if (t > (2 ** (OW - 1)) - 1) begin
            t  = (2 ** (OW - 1)) - 1;
            st = 1'b1;
        end else if (t < -(2 ** (OW - 1))) begin
            t  = -(2 ** (OW - 1));
            st = 1'b1;
        end
        q = t;
    endfunction

    // Reference model: tracks outstanding elements and frame acceptance.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                exp_q.delete();
                pending  = 0;
                exp_drop = 1'b0;
                started  = 1'b1;
            end else begin
                xfer_m   = (pending > 0) && m_ready;
                accept_m = valid_in && (pending == 0 || (pending == 1 && xfer_m));
                if (xfer_m) pending--;
                if (accept_m) begin
                    pending = 9;
                    for (int i = 0; i < 9; i++) begin
                        exp_t e;
                        int   q;
                        bit   st;
                        ref_elem(int'(c[i]), int'(shift_amt), relu_en, q, st);
                        e.data  = q;
                        e.sat   = st;
                        e.index = i;
                        e.last  = (i == 8);
                        exp_q.push_back(e);
                    end
                end else if (valid_in) begin
                    exp_drop = 1'b1;
                end
            end
        end
    end

    // Monitor: compares presented output with the scoreboard head, pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("m_valid", {31'd0, m_valid}, int'(pending > 0));
                chk("busy", {31'd0, busy}, int'(pending > 0));
                chk("drop_err", {31'd0, drop_err}, int'(exp_drop));
                if (!m_valid) begin
                    chk("m_last_idle", {31'd0, m_last}, 0);
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q[0];
                    chk("m_data", $signed(m_data), e.data);
                    chk("m_sat", {31'd0, m_sat}, int'(e.sat));
                    chk("m_index", {28'd0, m_index}, e.index);
                    chk("m_last", {31'd0, m_last}, int'(e.last));
                    if (m_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v[9], input int s, input bit r);
        for (int i = 0; i < 9; i++) c[i] = RW'(v[i]);
        shift_amt = SW'(s);
        relu_en   = r;
        valid_in  = 1'b1;
        step();
        valid_in = 1'b0;
        for (int i = 0; i < 9; i++) c[i] = RW'($urandom);
        shift_amt = SW'($urandom);
        relu_en   = 1'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (pending > 0 && n < budget) begin
            step();
            n++;
        end
        chk("idle_timeout", pending, 0);
    endtask

    task automatic rand_frame(output int v[9]);
        for (int i = 0; i < 9; i++) v[i] = $urandom_range(2000) - 1000;
    endtask

    initial begin
        int fr[9];
        for (int i = 0; i < 9; i++) c[i] = '0;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_m_valid", {31'd0, m_valid}, 0);
        chk("rst_m_last", {31'd0, m_last}, 0);
        chk("rst_m_index", {28'd0, m_index}, 0);
        chk("rst_m_sat", {31'd0, m_sat}, 0);
        chk("rst_m_data", $signed(m_data), 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_drop_err", {31'd0, drop_err}, 0);
        step();
        m_ready = 1'b1;

        send('{1, 2, 3, 4, 5, 6, 7, 8, 9}, 0, 1'b0);
        wait_idle(20);
        send('{300, -300, 127, 0, 0, 0, 0, 0, 0}, 0, 1'b0);
        wait_idle(20);
        send('{100, -7, 0, 0, 0, 0, 0, 0, 0}, 2, 1'b0);
        wait_idle(20);
        send('{100, -7, 0, 0, 0, 0, 0, 0, 0}, 2, 1'b1);
        wait_idle(20);
        send('{-7, 7, -1, 1, 0, 0, 0, 0, 0}, 1, 1'b0);
        wait_idle(20);

        // Backpressure at element 4.
        rand_frame(fr);
        send(fr, 1, 1'b0);
        repeat (4) step();
        m_ready = 1'b0;
        repeat (3) step();
        m_ready = 1'b1;
        wait_idle(20);

        // Frame arriving mid-stream is dropped.
        rand_frame(fr);
        send(fr, 0, 1'b0);
        repeat (3) step();
        rand_frame(fr);
        send(fr, 0, 1'b0);
        wait_idle(20);

        // Back-to-back: new frame exactly on the final transfer.
        rand_frame(fr);
        send(fr, 2, 1'b0);
        repeat (8) step();
        rand_frame(fr);
        send(fr, 3, 1'b1);
        wait_idle(20);

        // Reset mid-stream, then a fresh frame.
        rand_frame(fr);
        send(fr, 0, 1'b0);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        send('{9, 8, 7, 6, 5, 4, 3, 2, 1}, 0, 1'b0);
        wait_idle(20);

        // Randomized traffic with random backpressure and frame timing.
        repeat (400) begin
            m_ready = ($urandom_range(3) != 0);
            if ($urandom_range(9) == 0) begin
                for (int i = 0; i < 9; i++) c[i] = RW'($urandom);
                shift_amt = SW'($urandom);
                relu_en   = 1'($urandom);
                valid_in  = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            step();
        end
        valid_in = 1'b0;
        m_ready  = 1'b1;
        wait_idle(40);
        step();
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Sits directly downstream of the 3x3 systolic array.
- On the array's one-cycle valid pulse, captures all nine RESULT_WIDTH accumulators into a local frame buffer.
- Requantizes each value: arithmetic shift, optional ReLU, signed saturation to OUT_WIDTH.
- Streams the nine values in row-major order (c00..c22) over a valid/ready interface, freeing the array for the next start.

Parameters:
- RESULT_WIDTH, 16, width of signed accumulator inputs.
- OUT_WIDTH, 8, width of signed requantized output; must be less than or equal to RESULT_WIDTH.
- SHIFT_WIDTH, 4, width of the shift-amount input.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- c00_in..c22_in  in  RESULT_WIDTH each (9 ports)  signed results from the array.
- valid_in  in  1  one-cycle pulse; c*_in are valid this cycle.
- shift_amt  in  SHIFT_WIDTH  arithmetic right-shift amount; sampled at capture.
- relu_en  in  1  clamp negatives to 0; sampled at capture.
- m_data  out  OUT_WIDTH  signed requantized element.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  consumer accepts the element.
- m_last  out  1  high with element 8 (c22).
- m_index  out  4  element index 0..8 of m_data.
- m_sat  out  1  the current element was saturated.
- busy  out  1  frame held (state STREAM).
- drop_err  out  1  sticky: a frame arrived while busy and was discarded.

Behaviour:
- Reset values: m_valid=0, m_last=0, m_index=0, m_sat=0, m_data=0, busy=0, drop_err=0. State=IDLE. Buffer contents are don't-care.
- Reset mid-stream: the frame is discarded and outputs return to reset values on the next cycle.
- States are IDLE and STREAM.
- IDLE, valid_in=1: latch all 9 inputs plus shift_amt and relu_en; set idx=0; go to STREAM.
- Latency: valid_in at cycle N gives m_valid=1 with element 0 at cycle N+1.
- STREAM: m_valid=1 continuously. m_data, m_sat, m_index and m_last derive only from registered buffer, idx and latched config. There is no combinational path from m_ready or any input to the outputs.
- Transfer occurs when m_valid and m_ready are both high; idx increments.
- Final transfer (idx==8 with m_ready) and valid_in=0: go to IDLE next cycle, m_valid=0.
- Final transfer with valid_in=1 in the same cycle: capture the new frame, stay in STREAM, idx=0. This is back-to-back operation with no bubble.
- valid_in in STREAM other than on the final transfer: frame dropped, drop_err<=1 (sticky until rst). The current stream is unaffected.
- Backpressure: while m_ready=0, m_data, m_index, m_last and m_sat hold stable.
- Arithmetic, applied per element at output:
  - t = buf >>> shift_amt (sign-extending, floor).
  - If shift_amt >= RESULT_WIDTH, t = 0 for non-negative inputs and -1 for negative inputs.
  - If relu_en and t<0, t=0.
  - Saturate t to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; m_sat=1 if clamping occurred.
  - ReLU-zeroed values do not set m_sat.
- m_last = (idx==8) and m_valid.

Decomposition:
- Shared package holds:
  - state enum {IDLE, STREAM};
  - NUM_ELEMS=9;
  - IDX_WIDTH=4;
  - LAST_IDX=8.
- Sub-module requant_sat: purely combinational shift, ReLU and saturate for one element. Parameters RESULT_WIDTH, OUT_WIDTH, SHIFT_WIDTH; outputs value and sat flag. Instantiated once after the idx mux.

Test Plan:
- Basic stream: c = 1..9, shift 0, relu off, m_ready=1, valid_in at cycle N → m_data 1..9 on cycles N+1..N+9, m_index 0..8, m_last only with 9, busy drops at N+10.
- Saturation: c00=300, c01=-300, c02=127, others 0, OUT_WIDTH=8 → 127 (sat=1), -128 (sat=1), 127 (sat=0).
- Shift/ReLU:
  - c00=100, c01=-7, shift 2, relu off → 25, -2.
  - Same frame with relu on → 25, 0 (sat=0).
  - shift 1 on -7 → -4.
- Backpressure: m_ready low for 3 cycles at idx 4 → m_data, m_index and m_sat stable; no element lost or duplicated; total 9 transfers.
- Overlap and back-to-back:
  - valid_in with frame B at idx 3 → ignored, drop_err=1, frame A completes.
  - Frame C asserted exactly on A's final transfer → C element 0 follows next cycle with no bubble.
- Reset mid-stream: rst at idx 5 → next cycle m_valid=0, busy=0, drop_err=0; a new frame then streams from idx 0.
